adder_arb: RTL and testbench
============================

ADDER_ARB -- requirements
Module: adder_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 16, which sets the operand and sum width.
REQ-002 SHALL have parameter ADD_LAT, default 2, legal range 1..8, which is the cycles from add_vld to a valid add_sum/add_co on the adder input.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 req0_vld, req1_vld  input  1  requester operand valid.
REQ-006 req0_rdy, req1_rdy  output  1  requester ready (combinational).
REQ-007 req0_a, req0_b, req1_a, req1_b  input  WIDTH  requester operands.
REQ-008 add_a, add_b  output  WIDTH  registered operands to the shared adder.
REQ-009 add_vld  output  1  registered issue strobe to the adder.
REQ-010 add_sum  input  WIDTH, add_co  input  1  adder result and carry, valid ADD_LAT cycles after add_vld.
REQ-011 rsp0_vld, rsp1_vld  output  1  registered response strobes, one per requester.
REQ-012 rsp_sum  output  WIDTH, rsp_co  output  1  registered response data, shared by both requesters.
REQ-013 flush  input  1  request to stop issuing and drain the adder.
REQ-014 idle  output  1  no operations in flight and no grants pending.

Function
REQ-015 A transfer SHALL occur on reqN when reqN_vld and reqN_rdy are both high at a rising edge; at most one transfer per cycle.
REQ-016 reqN_rdy SHALL be high only when state is RUN, flush is low, and requester N wins arbitration.
- Requester N wins when only reqN_vld is high.
- When both are valid, the winner is the requester other than the last one granted.
REQ-017 The last-granted pointer SHALL update only on a transfer, and SHALL reset to 1 so that req0 wins the first tie.
REQ-018 On a transfer in cycle T:
- add_a, add_b SHALL take the winner's operands and add_vld SHALL be 1 in cycle T+1.
- Otherwise add_vld SHALL be 0 and add_a, add_b SHALL hold their values.
REQ-019 The block SHALL keep an ADD_LAT-deep valid/tag shift register aligned with add_vld.
REQ-020 The add_sum and add_co matching an issue SHALL be registered to rsp_sum and rsp_co, with the tagged rspN_vld high for exactly one cycle, in cycle T+ADD_LAT+2.
REQ-021 rsp_sum and rsp_co SHALL hold their value when no response is valid; rsp0_vld and rsp1_vld SHALL never be high together.
REQ-022 Responses SHALL return in issue order with no backpressure; the block SHALL accept one transfer every cycle with no bubbles.
REQ-023 The in-flight count SHALL be a counter of width ceil(log2(ADD_LAT+2))+1; it SHALL increment on issue and decrement on response, and a simultaneous increment and decrement SHALL leave it unchanged.
REQ-024 The FSM SHALL have three states:
- RUN: when flush is high, go to DRAIN.
- DRAIN: when the in-flight count is 0, go to HALT.
- HALT: when flush is low, go to RUN.
REQ-025 If flush rises in the same cycle as a would-be grant, flush SHALL win: no transfer occurs.
REQ-026 Operations already in flight when flush rises SHALL still complete and respond.
REQ-027 idle SHALL be high when state is HALT, or when state is RUN, the in-flight count is 0, and both reqN_vld inputs are low.

Reset
REQ-028 Asserting rst SHALL immediately force, regardless of clk:
- state to RUN and the last-granted pointer to 1;
- the in-flight count and tag pipeline to 0;
- add_vld, rsp0_vld, rsp1_vld to 0;
- add_a, add_b, rsp_sum, rsp_co to 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations with no responses; adder results returning after reset SHALL be ignored.
REQ-030 While rst is low, req0_rdy, req1_rdy and idle SHALL be 0.

Configuration
REQ-031 With macro ADDER_ARB_STATS_EN defined, the block SHALL add two outputs:
- gnt0_cnt, gnt1_cnt, output, 16 bits each, counting transfers per requester;
- each counter wraps from 65535 to 0 and resets to 0.
REQ-032 Without ADDER_ARB_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Single transfer: ADD_LAT=2, req0 transfers a=16'hFFFF, b=16'h0001 at cycle T -> add_vld at T+1, then rsp0_vld at T+4 with rsp_sum=16'h0000 and rsp_co=1.
REQ-034 Tie, round-robin: both valid continuously for 6 cycles after reset -> grant order 0,1,0,1,0,1, and responses alternate rsp0_vld/rsp1_vld back-to-back with no gaps.
REQ-035 Flush:
- Stimulus: after 3 back-to-back issues, raise flush.
- Rdy: both rdy go low that cycle.
- Responses: all 3 responses still arrive.
- State: DRAIN then HALT; idle goes to 1.
- Release: flush low -> grants resume next cycle.
REQ-036 Reset mid-flight: rst low while 2 operations are in flight -> no rsp*_vld ever appears for them, and all outputs read 0 during reset.
REQ-037 Single-requester streaming: only req1_vld held high for 10 cycles -> 10 transfers, 10 rsp1_vld pulses in order, and rsp0_vld never asserted.
REQ-038 With ADDER_ARB_STATS_EN: 65537 req0 transfers -> gnt0_cnt=1 (wrapped) and gnt1_cnt=0.

Source files
------------

// File: rtl/adder_arb.sv
// adder_arb -- two-requester round-robin front end for a shared pipelined adder.
//
// Requesters hand over operand pairs with a valid/ready handshake. The winner's
// operands are registered onto the adder issue port. A valid/tag pipeline tracks
// each operation so that the adder result, arriving ADD_LAT cycles after issue,
// is registered back to the requester that issued it. flush stops new grants
// and lets the in-flight operations drain before the block halts.
//
// Parameters
//   WIDTH    operand / sum width
//   ADD_LAT  adder latency in cycles from add_vld to add_sum/add_co (1..8)
// Ports
//   clk                          single clock, rising edge
//   rst                          asynchronous reset, active low
//   req0_vld/req1_vld            requester operand valid
//   req0_rdy/req1_rdy            requester ready (combinational)
//   req0_a/b, req1_a/b           requester operands
//   add_a/add_b/add_vld          registered issue to the shared adder
//   add_sum/add_co               adder result, valid ADD_LAT cycles after add_vld
//   rsp0_vld/rsp1_vld            registered one-cycle response strobes
//   rsp_sum/rsp_co               registered response data (shared)
//   flush                        stop issuing and drain
//   idle                         nothing in flight and nothing waiting
//   gnt0_cnt/gnt1_cnt            per-requester transfer counters, 16-bit wrapping
//                                (present only when ADDER_ARB_STATS_EN is defined)
module adder_arb #(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_vld,
    input  logic             req1_vld,
    output logic             req0_rdy,
    output logic             req1_rdy,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_vld,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_co,
    output logic             rsp0_vld,
    output logic             rsp1_vld,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_co,
    input  logic             flush,
    output logic             idle
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]      gnt0_cnt,
    output logic [15:0]      gnt1_cnt
`endif
);

    // Wide enough for every issue still awaiting its response (ADD_LAT+1 max).
    localparam int CW = $clog2(ADD_LAT + 2) + 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t             state, state_nxt;
    logic               last_gnt;   // 1: req1 was granted last
    logic               win0, win1, grant_ok;
    logic               xfer0, xfer1, xfer;
    logic               add_tag;    // requester id of the op currently on add_*
    logic [ADD_LAT-1:0] vpipe;      // valid, one stage per adder cycle after issue
    logic [ADD_LAT-1:0] tpipe;      // requester id travelling with vpipe
    logic               rsp_fire;
    logic [CW-1:0]      inflight;

    // Arbitration: a sole requester wins; on a tie the one not granted last wins.
    always_comb begin
        win0     = req0_vld && (!req1_vld || last_gnt);
        win1     = req1_vld && (!req0_vld || !last_gnt);
        grant_ok = rst && (state == RUN) && !flush;
        req0_rdy = grant_ok && win0;
        req1_rdy = grant_ok && win1;
        xfer0    = req0_vld && req0_rdy;
        xfer1    = req1_vld && req1_rdy;
        xfer     = xfer0 || xfer1;
        rsp_fire = vpipe[ADD_LAT-1];
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (flush)             state_nxt = DRAIN;
            DRAIN:   if (inflight == '0)    state_nxt = HALT;
            HALT:    if (!flush)            state_nxt = RUN;
            default:                        state_nxt = RUN;
        endcase
    end

    always_comb begin
        idle = rst && ((state == HALT) ||
                       ((state == RUN) && (inflight == '0) && !req0_vld && !req1_vld));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            if (xfer) last_gnt <= xfer1;
        end
    end

    // Issue register: operands hold between issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_a   <= '0;
            add_b   <= '0;
            add_vld <= 1'b0;
            add_tag <= 1'b0;
        end else begin
            add_vld <= xfer;
            if (xfer) begin
                add_a   <= xfer1 ? req1_a : req0_a;
                add_b   <= xfer1 ? req1_b : req0_b;
                add_tag <= xfer1;
            end
        end
    end

    // Stage 0 is loaded from add_vld, so the last stage is high exactly in the
    // cycle the adder presents the matching result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vpipe <= '0;
            tpipe <= '0;
        end else begin
            vpipe[0] <= add_vld;
            tpipe[0] <= add_tag;
            for (int unsigned i = 1; i < ADD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                tpipe[i] <= tpipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp0_vld <= 1'b0;
            rsp1_vld <= 1'b0;
            rsp_sum  <= '0;
            rsp_co   <= 1'b0;
        end else begin
            rsp0_vld <= rsp_fire && !tpipe[ADD_LAT-1];
            rsp1_vld <= rsp_fire &&  tpipe[ADD_LAT-1];
            if (rsp_fire) begin
                rsp_sum <= add_sum;
                rsp_co  <= add_co;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            unique case ({xfer, rsp_fire})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

`ifdef ADDER_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else begin
            if (xfer0) gnt0_cnt <= gnt0_cnt + 16'd1;
            if (xfer1) gnt1_cnt <= gnt1_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_arb.sv
// Self-checking bench for adder_arb. A behavioural adder with ADD_LAT cycles of
// latency sits on the issue port; expected responses are queued when a transfer
// is seen and popped when a response strobe appears.
module tb_adder_arb;

    localparam int WIDTH   = 16;
    localparam int ADD_LAT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_vld, req1_vld, req0_rdy, req1_rdy;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_vld, add_co;
    logic             rsp0_vld, rsp1_vld, rsp_co;
    logic [WIDTH-1:0] rsp_sum;
    logic             flush, idle;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0]      gnt0_cnt, gnt1_cnt;
`endif

    always #5 clk = ~clk;

    adder_arb #(.WIDTH(WIDTH), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req1_vld(req1_vld),
        .req0_rdy(req0_rdy), .req1_rdy(req1_rdy),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .add_a(add_a), .add_b(add_b), .add_vld(add_vld),
        .add_sum(add_sum), .add_co(add_co),
        .rsp0_vld(rsp0_vld), .rsp1_vld(rsp1_vld),
        .rsp_sum(rsp_sum), .rsp_co(rsp_co),
        .flush(flush), .idle(idle)
`ifdef ADDER_ARB_STATS_EN
        , .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
`endif
    );

    // Environment adder: never reset, so stale results keep arriving after a reset.
    logic [WIDTH:0] apipe [ADD_LAT];
    always @(posedge clk) begin
        apipe[0] <= {1'b0, add_a} + {1'b0, add_b};
        for (int i = 1; i < ADD_LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign add_sum = apipe[ADD_LAT-1][WIDTH-1:0];
    assign add_co  = apipe[ADD_LAT-1][WIDTH];

    typedef struct {
        logic             id;
        logic             co;
        logic [WIDTH-1:0] sum;
    } exp_t;

    exp_t             q[$];
    int               errors = 0;
    int               checks = 0;
    int               rsp0_seen = 0;
    int               rsp1_seen = 0;
    logic [WIDTH-1:0] last_sum = '0;
    logic             last_co = 1'b0;

    // One clock: scoreboard work at the falling edge, return 1 time unit after
    // the next rising edge with inputs left for the caller to change.
    task automatic step();
        exp_t           e;
        logic [WIDTH:0] s;
        @(negedge clk);
        checks++;
        if (rsp0_vld && rsp1_vld) begin
            errors++; $display("FAIL rsp_exclusive: rsp0_vld=%b rsp1_vld=%b required not both 1", rsp0_vld, rsp1_vld);
        end
        if (!rst) begin
            q.delete();
            last_sum = '0;
            last_co  = 1'b0;
        end else if (rsp0_vld || rsp1_vld) begin
            if (rsp0_vld) rsp0_seen++;
            if (rsp1_vld) rsp1_seen++;
            checks++;
            if (q.size() == 0) begin
                errors++; $display("FAIL rsp_unexpected: rsp0=%b rsp1=%b sum=%h, required no response", rsp0_vld, rsp1_vld, rsp_sum);
            end else begin
                e = q.pop_front();
                if (rsp1_vld !== e.id || rsp_sum !== e.sum || rsp_co !== e.co) begin
                    errors++; $display("FAIL rsp_data: id=%b sum=%h co=%b, required id=%b sum=%h co=%b", rsp1_vld, rsp_sum, rsp_co, e.id, e.sum, e.co);
                end
            end
            last_sum = rsp_sum;
            last_co  = rsp_co;
        end else begin
            checks++;
            if (rsp_sum !== last_sum || rsp_co !== last_co) begin
                errors++; $display("FAIL rsp_hold: sum=%h co=%b, required sum=%h co=%b", rsp_sum, rsp_co, last_sum, last_co);
            end
        end
        if (rst && req0_vld && req0_rdy) begin
            s = {1'b0, req0_a} + {1'b0, req0_b};
            q.push_back('{1'b0, s[WIDTH], s[WIDTH-1:0]});
        end
        if (rst && req1_vld && req1_rdy) begin
            s = {1'b0, req1_a} + {1'b0, req1_b};
            q.push_back('{1'b1, s[WIDTH], s[WIDTH-1:0]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        for (int i = 0; i < ADD_LAT + 6; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0;
        req0_vld = 1'b0; req1_vld = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        step(); step();
        req0_vld = 1'b1; req1_vld = 1'b1;
        #1;
        checks++;
        if ({req0_rdy, req1_rdy, idle, add_vld, rsp0_vld, rsp1_vld, rsp_co} !== 7'b0) begin
            errors++; $display("FAIL reset_ctl: rdy0=%b rdy1=%b idle=%b add_vld=%b rsp0=%b rsp1=%b co=%b, required all 0",
                              req0_rdy, req1_rdy, idle, add_vld, rsp0_vld, rsp1_vld, rsp_co);
        end
        checks++;
        if (add_a !== '0 || add_b !== '0 || rsp_sum !== '0) begin
            errors++; $display("FAIL reset_data: add_a=%h add_b=%h rsp_sum=%h, required 0", add_a, add_b, rsp_sum);
        end
        step();
        req0_vld = 1'b0; req1_vld = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL reset_idle: idle=%b, required 1", idle);
        end
    endtask

    task automatic test_tie();
        for (int i = 0; i < 12; i++) begin
            if (i < 6) begin
                req0_vld = 1'b1; req1_vld = 1'b1;
                req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom);
                req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom);
                #1;
                checks++;
                if (req0_rdy !== (i % 2 == 0) || req1_rdy !== (i % 2 == 1)) begin
                    errors++; $display("FAIL tie_grant[%0d]: rdy0=%b rdy1=%b, required rdy0=%b rdy1=%b",
                                      i, req0_rdy, req1_rdy, i % 2 == 0, i % 2 == 1);
                end
            end else begin
                req0_vld = 1'b0; req1_vld = 1'b0;
            end
            step();
            if (i + 1 >= 4 && i + 1 <= 9) begin
                checks++;
                if (rsp0_vld !== ((i - 3) % 2 == 0) || rsp1_vld !== ((i - 3) % 2 == 1)) begin
                    errors++; $display("FAIL tie_rsp[%0d]: rsp0=%b rsp1=%b, required rsp0=%b rsp1=%b",
                                      i + 1, rsp0_vld, rsp1_vld, (i - 3) % 2 == 0, (i - 3) % 2 == 1);
                end
            end
        end
        drain();
    endtask

    task automatic test_single();
        req0_vld = 1'b1; req0_a = 16'hFFFF; req0_b = 16'h0001;
        #1;
        checks++;
        if (req0_rdy !== 1'b1) begin
            errors++; $display("FAIL single_rdy: rdy0=%b, required 1", req0_rdy);
        end
        step();
        checks++;
        if (add_vld !== 1'b1 || add_a !== 16'hFFFF || add_b !== 16'h0001) begin
            errors++; $display("FAIL single_issue: add_vld=%b a=%h b=%h, required 1 ffff 0001", add_vld, add_a, add_b);
        end
        req0_vld = 1'b0; req0_a = 16'h1234;
        step();
        checks++;
        if (add_vld !== 1'b0 || add_a !== 16'hFFFF) begin
            errors++; $display("FAIL single_hold: add_vld=%b a=%h, required 0 ffff", add_vld, add_a);
        end
        step();
        checks++;
        if (rsp0_vld !== 1'b0) begin
            errors++; $display("FAIL single_early: rsp0_vld=%b at T+3, required 0", rsp0_vld);
        end
        step();
        checks++;
        if (rsp0_vld !== 1'b1 || rsp1_vld !== 1'b0 || rsp_sum !== 16'h0000 || rsp_co !== 1'b1) begin
            errors++; $display("FAIL single_rsp: rsp0=%b rsp1=%b sum=%h co=%b, required 1 0 0000 1", rsp0_vld, rsp1_vld, rsp_sum, rsp_co);
        end
        step();
        checks++;
        if (rsp0_vld !== 1'b0) begin
            errors++; $display("FAIL single_pulse: rsp0_vld=%b at T+5, required 0", rsp0_vld);
        end
        drain();
    endtask

    task automatic test_stream();
        rsp0_seen = 0; rsp1_seen = 0;
        for (int i = 0; i < 10; i++) begin
            req1_vld = 1'b1;
            req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom);
            #1;
            checks++;
            if (req1_rdy !== 1'b1) begin
                errors++; $display("FAIL stream_rdy[%0d]: rdy1=%b, required 1", i, req1_rdy);
            end
            step();
        end
        drain();
        checks++;
        if (rsp1_seen !== 10 || rsp0_seen !== 0) begin
            errors++; $display("FAIL stream_count: rsp1=%0d rsp0=%0d, required 10 0", rsp1_seen, rsp0_seen);
        end
    endtask

    task automatic test_flush();
        int n;
        rsp0_seen = 0; rsp1_seen = 0;
        for (int i = 0; i < 3; i++) begin
            req0_vld = 1'b1; req1_vld = 1'b1;
            req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom);
            req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom);
            step();
        end
        flush = 1'b1;
        #1;
        checks++;
        if (req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
            errors++; $display("FAIL flush_rdy: rdy0=%b rdy1=%b, required 0 0", req0_rdy, req1_rdy);
        end
        n = 0;
        while (n < 20 && idle !== 1'b1) begin
            step();
            n++;
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL flush_idle: idle=%b after %0d cycles, required 1", idle, n);
        end
        checks++;
        if (rsp0_seen + rsp1_seen !== 3) begin
            errors++; $display("FAIL flush_rsp: responses=%0d, required 3", rsp0_seen + rsp1_seen);
        end
        step();
        checks++;
        if (req0_rdy !== 1'b0 || req1_rdy !== 1'b0 || idle !== 1'b1) begin
            errors++; $display("FAIL flush_halt: rdy0=%b rdy1=%b idle=%b, required 0 0 1", req0_rdy, req1_rdy, idle);
        end
        flush = 1'b0;
        #1;
        checks++;
        if (req0_rdy !== 1'b0 || req1_rdy !== 1'b0) begin
            errors++; $display("FAIL flush_release_same: rdy0=%b rdy1=%b, required 0 0", req0_rdy, req1_rdy);
        end
        step();
        checks++;
        if ((req0_rdy ^ req1_rdy) !== 1'b1) begin
            errors++; $display("FAIL flush_resume: rdy0=%b rdy1=%b, required exactly one 1", req0_rdy, req1_rdy);
        end
        drain();
    endtask

    task automatic test_midreset();
        req0_vld = 1'b1;
        req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom);
        step();
        req0_a = WIDTH'($urandom);
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({req0_rdy, req1_rdy, idle, add_vld, rsp0_vld, rsp1_vld, rsp_co} !== 7'b0 ||
            add_a !== '0 || add_b !== '0 || rsp_sum !== '0) begin
            errors++; $display("FAIL midreset_outputs: rdy0=%b idle=%b add_vld=%b a=%h b=%h rsp0=%b rsp1=%b sum=%h co=%b, required all 0",
                              req0_rdy, idle, add_vld, add_a, add_b, rsp0_vld, rsp1_vld, rsp_sum, rsp_co);
        end
        step(); step(); step();
        req0_vld = 1'b0;
        rst = 1'b1;
        rsp0_seen = 0; rsp1_seen = 0;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (rsp0_seen + rsp1_seen !== 0) begin
            errors++; $display("FAIL midreset_rsp: responses=%0d, required 0", rsp0_seen + rsp1_seen);
        end
    endtask

`ifdef ADDER_ARB_STATS_EN
    task automatic test_stats();
        rst = 1'b0;
        step();
        rst = 1'b1;
        req0_vld = 1'b1;
        for (int i = 0; i < 65537; i++) step();
        req0_vld = 1'b0;
        step();
        checks++;
        if (gnt0_cnt !== 16'd1 || gnt1_cnt !== 16'd0) begin
            errors++; $display("FAIL stats_wrap: gnt0=%0d gnt1=%0d, required 1 0", gnt0_cnt, gnt1_cnt);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_stream();
        test_flush();
        test_midreset();
`ifdef ADDER_ARB_STATS_EN
        test_stats();
`endif
        checks++;
        if (q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_empty: pending=%0d, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
